decode_pipe_stage: RTL

DECODE_PIPE_STAGE -- requirements
Module: decode_pipe_stage

---
 rtl/decode_pipe_stage_pkg.sv | 46 ++++
 rtl/decode_pipe_entry.sv | 129 ++++++++++++
 rtl/decode_pipe_stage.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/decode_pipe_stage_pkg.sv
// Shared decode-stage definitions: default widths, instruction field positions,
// control bundle bit layout and the destination-register source selector.
// Ports: none (package).
package decode_pipe_stage_pkg;

    // Default widths
    localparam int unsigned DEF_DATA_W  = 18;
    localparam int unsigned DEF_PC_W    = 18;
    localparam int unsigned DEF_INSTR_W = 33;
    localparam int unsigned DEF_REG_AW  = 5;
    localparam int unsigned DEF_CTRL_W  = 10;

    // Instruction field positions (LSB of each register field, REG_AW bits wide)
    localparam int unsigned RS1_LSB     = 23;
    localparam int unsigned RS2_LSB     = 18;
    localparam int unsigned RD_LSB      = 0;
    localparam int unsigned TYPE_LSB    = 30;  // 2-bit type field [31:30]
    localparam int unsigned IMM_SEL_BIT = 32;
    localparam logic [1:0]  TYPE_RD_IS_RS1 = 2'b01;

    // Control bundle layout; carried through the stage without interpretation
    localparam int unsigned CTRL_REGWRITE  = 9;
    localparam int unsigned CTRL_ALUSRC    = 8;
    localparam int unsigned CTRL_MEMWRITE  = 7;
    localparam int unsigned CTRL_RESULTSRC = 6;
    localparam int unsigned CTRL_BRANCH    = 5;
    localparam int unsigned CTRL_ALUCTL_LSB = 2;  // ALUControl[2:0]
    localparam int unsigned CTRL_RGB_LSB   = 0;   // RGB[1:0]

    typedef enum logic [1:0] {
        RdFromLow = 2'd0,
        RdFromRs1 = 2'd1,
        RdFromRs2 = 2'd2
    } rd_src_e;

    // Type field takes precedence over the immediate-select bit.
    function automatic rd_src_e f_rd_src(input logic [1:0] typ, input logic imm_sel);
        if (typ == TYPE_RD_IS_RS1) begin
            return RdFromRs1;
        end else if (imm_sel) begin
            return RdFromRs2;
        end
        return RdFromLow;
    endfunction

endpackage

// File: rtl/decode_pipe_entry.sv
// One decode pipeline slot: payload register, valid bit and write-back bypass.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_capture           load i_* payload and set valid
//   i_clear             drop the entry (valid -> 0); never asserted with i_capture
//   i_ctrl..i_pc_plus4  payload to capture
//   i_wb_we/rd/data     write-back port used to refresh rd1/rd2
//   o_valid, o_*        held entry
module decode_pipe_entry
    import decode_pipe_stage_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned PC_W     = DEF_PC_W,
    parameter int unsigned REG_AW   = DEF_REG_AW,
    parameter int unsigned CTRL_W   = DEF_CTRL_W,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_capture,
    input  logic              i_clear,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_rd1,
    input  logic [DATA_W-1:0] i_rd2,
    input  logic [DATA_W-1:0] i_imm,
    input  logic [REG_AW-1:0] i_rs1,
    input  logic [REG_AW-1:0] i_rs2,
    input  logic [REG_AW-1:0] i_rd,
    input  logic [PC_W-1:0]   i_pc,
    input  logic [PC_W-1:0]   i_pc_plus4,
    input  logic              i_wb_we,
    input  logic [REG_AW-1:0] i_wb_rd,
    input  logic [DATA_W-1:0] i_wb_data,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_rd1,
    output logic [DATA_W-1:0] o_rd2,
    output logic [DATA_W-1:0] o_imm,
    output logic [REG_AW-1:0] o_rs1,
    output logic [REG_AW-1:0] o_rs2,
    output logic [REG_AW-1:0] o_rd,
    output logic [PC_W-1:0]   o_pc,
    output logic [PC_W-1:0]   o_pc_plus4
);

    logic              r_valid;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_rd1;
    logic [DATA_W-1:0] r_rd2;
    logic [DATA_W-1:0] r_imm;
    logic [REG_AW-1:0] r_rs1;
    logic [REG_AW-1:0] r_rs2;
    logic [REG_AW-1:0] r_rd;
    logic [PC_W-1:0]   r_pc;
    logic [PC_W-1:0]   r_pc_plus4;

    logic [REG_AW-1:0] w_rs1_src;
    logic [REG_AW-1:0] w_rs2_src;
    logic [DATA_W-1:0] w_rd1_d;
    logic [DATA_W-1:0] w_rd2_d;
    logic              w_refresh;

    // Register 0 is never bypassed when it is hard-wired to zero.
    function automatic logic f_wb_hit(input logic              we,
                                      input logic [REG_AW-1:0] wb_rd,
                                      input logic [REG_AW-1:0] rs);
        return we && (wb_rd == rs) && ((ZERO_REG == 0) || (rs != '0));
    endfunction

    // Bypass applies to the value being captured, or to a live held entry.
    assign w_refresh = i_capture || r_valid;
    assign w_rs1_src = i_capture ? i_rs1 : r_rs1;
    assign w_rs2_src = i_capture ? i_rs2 : r_rs2;

    always_comb begin
        w_rd1_d = i_capture ? i_rd1 : r_rd1;
        w_rd2_d = i_capture ? i_rd2 : r_rd2;
        if (w_refresh && f_wb_hit(i_wb_we, i_wb_rd, w_rs1_src)) begin
            w_rd1_d = i_wb_data;
        end
        if (w_refresh && f_wb_hit(i_wb_we, i_wb_rd, w_rs2_src)) begin
            w_rd2_d = i_wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_ctrl     <= '0;
            r_rd1      <= '0;
            r_rd2      <= '0;
            r_imm      <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_pc       <= '0;
            r_pc_plus4 <= '0;
        end else begin
            if (i_clear) begin
                r_valid <= 1'b0;
            end else if (i_capture) begin
                r_valid <= 1'b1;
            end
            if (i_capture) begin
                r_ctrl     <= i_ctrl;
                r_imm      <= i_imm;
                r_rs1      <= i_rs1;
                r_rs2      <= i_rs2;
                r_rd       <= i_rd;
                r_pc       <= i_pc;
                r_pc_plus4 <= i_pc_plus4;
            end
            r_rd1 <= w_rd1_d;
            r_rd2 <= w_rd2_d;
        end
    end

    assign o_valid    = r_valid;
    assign o_ctrl     = r_ctrl;
    assign o_rd1      = r_rd1;
    assign o_rd2      = r_rd2;
    assign o_imm      = r_imm;
    assign o_rs1      = r_rs1;
    assign o_rs2      = r_rs2;
    assign o_rd       = r_rd;
    assign o_pc       = r_pc;
    assign o_pc_plus4 = r_pc_plus4;

endmodule

// File: rtl/decode_pipe_stage.sv
// Decode -> execute pipeline register with a skid buffer.
// Two slots: OUT drives the execute side, SKID catches one entry while OUT
// stalls so in_ready can come straight from a register.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid/in_ready              decode-side handshake
//   instr_d, ctrl_d, rd1_d, rd2_d,
//   imm_d, pc_d, pc_plus4_d        decode payload
//   wb_we, wb_rd, wb_data          write-back port for operand refresh
//   flush                          squash all held entries
//   out_valid/out_ready            execute-side handshake
//   ctrl_e .. pc_plus4_e           execute payload (ctrl_e zero on bubbles)
module decode_pipe_stage
    import decode_pipe_stage_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned PC_W     = DEF_PC_W,
    parameter int unsigned INSTR_W  = DEF_INSTR_W,
    parameter int unsigned REG_AW   = DEF_REG_AW,
    parameter int unsigned CTRL_W   = DEF_CTRL_W,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr_d,
    input  logic [CTRL_W-1:0]  ctrl_d,
    input  logic [DATA_W-1:0]  rd1_d,
    input  logic [DATA_W-1:0]  rd2_d,
    input  logic [DATA_W-1:0]  imm_d,
    input  logic [PC_W-1:0]    pc_d,
    input  logic [PC_W-1:0]    pc_plus4_d,
    input  logic               wb_we,
    input  logic [REG_AW-1:0]  wb_rd,
    input  logic [DATA_W-1:0]  wb_data,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CTRL_W-1:0]  ctrl_e,
    output logic [DATA_W-1:0]  rd1_e,
    output logic [DATA_W-1:0]  rd2_e,
    output logic [DATA_W-1:0]  imm_e,
    output logic [REG_AW-1:0]  rs1_e,
    output logic [REG_AW-1:0]  rs2_e,
    output logic [REG_AW-1:0]  rd_e,
    output logic [PC_W-1:0]    pc_e,
    output logic [PC_W-1:0]    pc_plus4_e
);

    // Decoded register addresses
    logic [REG_AW-1:0] w_rs1;
    logic [REG_AW-1:0] w_rs2;
    logic [REG_AW-1:0] w_rd;

    assign w_rs1 = instr_d[RS1_LSB +: REG_AW];
    assign w_rs2 = instr_d[RS2_LSB +: REG_AW];

    always_comb begin
        w_rd = instr_d[RD_LSB +: REG_AW];
        unique case (f_rd_src(instr_d[TYPE_LSB +: 2], instr_d[IMM_SEL_BIT]))
            RdFromRs1: w_rd = w_rs1;
            RdFromRs2: w_rd = w_rs2;
            default:   w_rd = instr_d[RD_LSB +: REG_AW];
        endcase
    end

    // Slot outputs
    logic              w_out_valid;
    logic [CTRL_W-1:0] w_out_ctrl;
    logic              w_skid_valid;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_rd1;
    logic [DATA_W-1:0] w_skid_rd2;
    logic [DATA_W-1:0] w_skid_imm;
    logic [REG_AW-1:0] w_skid_rs1;
    logic [REG_AW-1:0] w_skid_rs2;
    logic [REG_AW-1:0] w_skid_rd;
    logic [PC_W-1:0]   w_skid_pc;
    logic [PC_W-1:0]   w_skid_pc_plus4;

    // Handshake and slot control
    logic w_in_fire;
    logic w_out_fire;
    logic w_out_take;
    logic w_out_capture;
    logic w_out_clear;
    logic w_skid_capture;
    logic w_skid_clear;

    // Skid occupancy is registered, so no out_ready -> in_ready path exists.
    assign in_ready   = !w_skid_valid && !rst;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = w_out_valid && out_ready;
    // OUT may reload this cycle: it is empty or its entry is leaving.
    assign w_out_take = !w_out_valid || w_out_fire;

    assign w_out_capture  = !flush && w_out_take && (w_skid_valid || w_in_fire);
    assign w_out_clear    = flush || (w_out_take && !w_skid_valid && !w_in_fire);
    assign w_skid_capture = !flush && w_in_fire && !w_out_take;
    assign w_skid_clear   = flush || (w_out_take && w_skid_valid);

    // OUT source: the older SKID entry always goes first.
    logic [CTRL_W-1:0] w_src_ctrl;
    logic [DATA_W-1:0] w_src_rd1;
    logic [DATA_W-1:0] w_src_rd2;
    logic [DATA_W-1:0] w_src_imm;
    logic [REG_AW-1:0] w_src_rs1;
    logic [REG_AW-1:0] w_src_rs2;
    logic [REG_AW-1:0] w_src_rd;
    logic [PC_W-1:0]   w_src_pc;
    logic [PC_W-1:0]   w_src_pc_plus4;

    assign w_src_ctrl     = w_skid_valid ? w_skid_ctrl     : ctrl_d;
    assign w_src_rd1      = w_skid_valid ? w_skid_rd1      : rd1_d;
    assign w_src_rd2      = w_skid_valid ? w_skid_rd2      : rd2_d;
    assign w_src_imm      = w_skid_valid ? w_skid_imm      : imm_d;
    assign w_src_rs1      = w_skid_valid ? w_skid_rs1      : w_rs1;
    assign w_src_rs2      = w_skid_valid ? w_skid_rs2      : w_rs2;
    assign w_src_rd       = w_skid_valid ? w_skid_rd       : w_rd;
    assign w_src_pc       = w_skid_valid ? w_skid_pc       : pc_d;
    assign w_src_pc_plus4 = w_skid_valid ? w_skid_pc_plus4 : pc_plus4_d;

    decode_pipe_entry #(
        .DATA_W  (DATA_W),
        .PC_W    (PC_W),
        .REG_AW  (REG_AW),
        .CTRL_W  (CTRL_W),
        .ZERO_REG(ZERO_REG)
    ) u_skid (
        .clk       (clk),
        .rst       (rst),
        .i_capture (w_skid_capture),
        .i_clear   (w_skid_clear),
        .i_ctrl    (ctrl_d),
        .i_rd1     (rd1_d),
        .i_rd2     (rd2_d),
        .i_imm     (imm_d),
        .i_rs1     (w_rs1),
        .i_rs2     (w_rs2),
        .i_rd      (w_rd),
        .i_pc      (pc_d),
        .i_pc_plus4(pc_plus4_d),
        .i_wb_we   (wb_we),
        .i_wb_rd   (wb_rd),
        .i_wb_data (wb_data),
        .o_valid   (w_skid_valid),
        .o_ctrl    (w_skid_ctrl),
        .o_rd1     (w_skid_rd1),
        .o_rd2     (w_skid_rd2),
        .o_imm     (w_skid_imm),
        .o_rs1     (w_skid_rs1),
        .o_rs2     (w_skid_rs2),
        .o_rd      (w_skid_rd),
        .o_pc      (w_skid_pc),
        .o_pc_plus4(w_skid_pc_plus4)
    );

    decode_pipe_entry #(
        .DATA_W  (DATA_W),
        .PC_W    (PC_W),
        .REG_AW  (REG_AW),
        .CTRL_W  (CTRL_W),
        .ZERO_REG(ZERO_REG)
    ) u_out (
        .clk       (clk),
        .rst       (rst),
        .i_capture (w_out_capture),
        .i_clear   (w_out_clear),
        .i_ctrl    (w_src_ctrl),
        .i_rd1     (w_src_rd1),
        .i_rd2     (w_src_rd2),
        .i_imm     (w_src_imm),
        .i_rs1     (w_src_rs1),
        .i_rs2     (w_src_rs2),
        .i_rd      (w_src_rd),
        .i_pc      (w_src_pc),
        .i_pc_plus4(w_src_pc_plus4),
        .i_wb_we   (wb_we),
        .i_wb_rd   (wb_rd),
        .i_wb_data (wb_data),
        .o_valid   (w_out_valid),
        .o_ctrl    (w_out_ctrl),
        .o_rd1     (rd1_e),
        .o_rd2     (rd2_e),
        .o_imm     (imm_e),
        .o_rs1     (rs1_e),
        .o_rs2     (rs2_e),
        .o_rd      (rd_e),
        .o_pc      (pc_e),
        .o_pc_plus4(pc_plus4_e)
    );

    assign out_valid = w_out_valid;
    // Bubbles must not carry RegWrite/MemWrite/Branch downstream.
    assign ctrl_e    = w_out_valid ? w_out_ctrl : '0;

endmodule
